// File: rtl/fare_pkg.sv
// fare_pkg: shared types and network topology tables for the fare lookup engine.
package fare_pkg;
    localparam int MAX_LINES = 8;
    typedef enum logic [2:0] {IDLE, INDEX, READ, WAIT, RESP} state_e;
    // Unused lines have length 0, so every station on them is out of range
    localparam int LINE_OFS [MAX_LINES] = '{0, 27, 53, 82, 100, 100, 100, 100};
    localparam int LINE_LEN [MAX_LINES] = '{27, 26, 29, 18, 0, 0, 0, 0};
endpackage

// File: rtl/fare_lookup_station_index.sv
// station_index: maps (line, station-on-line) to a global station index plus range flag.
module station_index
    import fare_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int LINE_W    = 2,
    parameter int POINT_W   = 5,
    parameter int IDX_W     = 7
) (
    input  logic [LINE_W-1:0]  line_i,
    input  logic [POINT_W-1:0] point_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               in_range_o
);
    logic [2:0] l;
    assign l          = 3'(line_i);
    assign in_range_o = (int'(line_i) < NUM_LINES) && (int'(point_i) < LINE_LEN[l]);
    assign idx_o      = IDX_W'(LINE_OFS[l] + int'(point_i));
endmodule

// File: rtl/fare_lookup.sv
// fare_lookup: one-query-at-a-time fare table lookup over valid/ready, reading a
// synchronous fare RAM at start_idx*NUM_STATIONS + end_idx.
module fare_lookup
    import fare_pkg::*;
#(
    parameter int NUM_LINES    = 4,
    parameter int LINE_W       = 2,
    parameter int POINT_W      = 5,
    parameter int NUM_STATIONS = 100,
    parameter int ADDR_W       = 14,
    parameter int PRICE_W      = 8,
    parameter int RD_LAT       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LINE_W-1:0]  start_line,
    input  logic [POINT_W-1:0] start_point,
    input  logic [LINE_W-1:0]  end_line,
    input  logic [POINT_W-1:0] end_point,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [PRICE_W-1:0] price,
    output logic               err,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PRICE_W-1:0] mem_dout
);
    localparam int IDX_W = $clog2(NUM_STATIONS);

    if (NUM_STATIONS * NUM_STATIONS > 2 ** ADDR_W) begin : g_addr_chk
        $error("fare_lookup: ADDR_W too small for NUM_STATIONS");
    end
    if (RD_LAT < 1 || RD_LAT > 4 || NUM_LINES < 1 || NUM_LINES > MAX_LINES) begin : g_par_chk
        $error("fare_lookup: RD_LAT or NUM_LINES out of range");
    end

    state_e             state_q, state_d;
    logic [LINE_W-1:0]  sl_q, sl_d, el_q, el_d;
    logic [POINT_W-1:0] sp_q, sp_d, ep_q, ep_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   s_idx, e_idx;
    logic               s_ok, e_ok, accept;

    station_index #(.NUM_LINES(NUM_LINES), .LINE_W(LINE_W), .POINT_W(POINT_W), .IDX_W(IDX_W)) u_start (
        .line_i(sl_q), .point_i(sp_q), .idx_o(s_idx), .in_range_o(s_ok)
    );
    station_index #(.NUM_LINES(NUM_LINES), .LINE_W(LINE_W), .POINT_W(POINT_W), .IDX_W(IDX_W)) u_end (
        .line_i(el_q), .point_i(ep_q), .idx_o(e_idx), .in_range_o(e_ok)
    );

    assign accept = (state_q == IDLE) && req_valid;
    assign sl_d   = accept ? start_line  : sl_q;
    assign sp_d   = accept ? start_point : sp_q;
    assign el_d   = accept ? end_line    : el_q;
    assign ep_d   = accept ? end_point   : ep_q;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        price_d    = price_q;
        err_d      = err_q;
        case (state_q)
            IDLE:  state_d = accept ? INDEX : IDLE;
            INDEX: begin
                state_d = (s_ok && e_ok && s_idx != e_idx) ? READ : RESP;
                err_d   = !(s_ok && e_ok);
                price_d = '0;
                if (s_ok && e_ok && s_idx != e_idx)
                    mem_addr_d = ADDR_W'(s_idx) * ADDR_W'(NUM_STATIONS) + ADDR_W'(e_idx);
            end
            READ: begin
                cnt_d   = 2'(RD_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    price_d = mem_dout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sl_q       <= '0;
            sp_q       <= '0;
            el_q       <= '0;
            ep_q       <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            price_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sl_q       <= sl_d;
            sp_q       <= sp_d;
            el_q       <= el_d;
            ep_q       <= ep_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            price_q    <= price_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign mem_en     = state_q == READ;
    assign mem_addr   = mem_addr_q;
    assign price      = price_q;
    assign err        = err_q;
endmodule

// File: doc/fare_lookup.md
Name: fare_lookup

Overview:
Parametrised fare-table lookup engine for the underway sales machine. It takes a (start line, start station) to (end line, end station) query over a valid/ready handshake and linearises each station to a global index. It then reads a synchronous block-RAM fare table at address start_idx*NUM_STATIONS + end_idx and returns the fare with an error flag. It sits between the ticket-selection FSM and the fare block memory, and replaces the free-running combinational address generator.

Parameters:
NUM_LINES, 4, number of metro lines (1..8)
LINE_W, 2, width of line select ($clog2(NUM_LINES), min 1)
POINT_W, 5, width of station-on-line select
NUM_STATIONS, 100, total stations; must equal the sum of LINE_LEN
ADDR_W, 14, fare memory address width; elaboration assert NUM_STATIONS*NUM_STATIONS <= 2**ADDR_W
PRICE_W, 8, fare data width
RD_LAT, 2, fare memory read latency in cycles (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  query present
req_ready  out  1  engine can accept a query
start_line  in  LINE_W  departure line
start_point  in  POINT_W  departure station within line
end_line  in  LINE_W  destination line
end_point  in  POINT_W  destination station within line
resp_valid  out  1  result held valid
resp_ready  in  1  consumer accepts result
price  out  PRICE_W  fare (0 when err or same station)
err  out  1  query out of range
mem_en  out  1  fare memory read enable
mem_addr  out  ADDR_W  fare memory address
mem_dout  in  PRICE_W  fare memory read data, valid RD_LAT cycles after mem_en

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; resp_valid=0; price=0; err=0; mem_en=0; mem_addr=0; latency counter=0.
- States: IDLE, INDEX, READ, WAIT, RESP.
- IDLE: req_ready=1. A query is accepted when req_valid&&req_ready. Inputs are registered on acceptance and the FSM moves to INDEX. req_ready=0 in every other state, so at most one query is in flight.
- INDEX (1 cycle): idx = LINE_OFS[line] + point for both ends. Range error if line>=NUM_LINES or point>=LINE_LEN[line] on either end.
  - Error: err=1, price=0, go to RESP. No memory access.
  - start_idx==end_idx: err=0, price=0, go to RESP. No memory access.
  - Otherwise: register mem_addr = start_idx*NUM_STATIONS + end_idx, computed at ADDR_W bits with no truncation, then go to READ.
- READ (1 cycle): mem_en=1. Load the counter with RD_LAT-1. Go to WAIT.
- WAIT: mem_en=0. The counter decrements each cycle. When the counter reaches 0, capture price=mem_dout and err=0, then go to RESP. mem_dout is sampled exactly RD_LAT cycles after the mem_en cycle.
- RESP: resp_valid=1. price and err stay stable until resp_valid&&resp_ready, then go to IDLE with resp_valid=0 on the next cycle.
  - No bypass: the earliest next acceptance is the cycle after the handshake.
  - resp_ready held high: the response completes in the first RESP cycle.
- Latency, acceptance edge to resp_valid rising:
  - Normal read: 3+RD_LAT cycles.
  - Error or same-station: 2 cycles.
- Input changes while busy are ignored because the query was registered at acceptance.
- rst_n asserted in any state returns everything to reset values immediately. A pending memory read is abandoned and its data is never captured.
- mem_addr holds its last value outside READ and WAIT.

Decomposition:
- Package fare_pkg holds:
  - the state enum type
  - LINE_OFS constant array {0,27,53,82}
  - LINE_LEN constant array {27,26,29,18}
  - the MAX_LINES=8 bound
- LINE_OFS and LINE_LEN are padded to MAX_LINES; unused entries have length 0, so any station on them is an error.
- One natural sub-module: station_index. It is combinational and maps (line, point) to (idx, in_range), with two instances for start and end. The FSM, counter and registers stay in fare_lookup.

Test Plan:
1. Normal read. Query start=(1,3), end=(2,5), memory preloaded with addr 3058=8'd12, RD_LAT=2 -> idx 30 and 58, mem_addr=3058, one mem_en pulse. resp_valid rises 5 cycles after acceptance with price=12, err=0.
2. Same station. Start=end=(3,4) (idx 86) -> no mem_en. resp_valid after 2 cycles with price=0, err=0.
3. Range error. start=(3,18), line length 18 -> err=1, price=0, no mem_en, resp_valid after 2 cycles. A second query with end_line=2, end_point=29 also gives err=1.
4. Backpressure. resp_ready=0 for 10 cycles in RESP -> price and err stable, req_ready=0, a second req_valid is not accepted. After resp_ready=1, it is accepted the cycle after the handshake.
5. Reset mid-read. rst_n pulsed low during WAIT -> outputs go to reset values immediately. The stale mem_dout is not reflected. A new query (0,0)->(0,1) then returns the addr 1 contents.
6. Parameter sweep. RD_LAT=1 and 4, back-to-back queries with resp_ready=1 -> mem_dout is sampled exactly RD_LAT cycles after mem_en. Throughput is one result per 4+RD_LAT cycles.
